fifo_serial_tx: RTL

FIFO_SERIAL_TX -- requirements
Module: fifo_serial_tx

---
 rtl/fifo_serial_tx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fifo_serial_tx.sv
// Serial transmitter fed by a valid/yumi upstream (e.g. a FIFO): start bit, LSB-first data, stop bit.
// Optional even-parity bit between data and stop when FIFO_SERIAL_TX_PARITY_EN is defined.
module fifo_serial_tx #(
  parameter int width_p        = 8,
  parameter int clks_per_bit_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [width_p-1:0] data_i,
  output logic               yumi_o,
  output logic               tx_o,
  output logic               busy_o
);

  localparam int cnt_w_lp = $clog2(clks_per_bit_p);
  localparam int idx_w_lp = $clog2(width_p + 1);
  localparam logic [cnt_w_lp-1:0] cnt_last_lp = cnt_w_lp'(clks_per_bit_p - 1);
  localparam logic [idx_w_lp-1:0] idx_last_lp = idx_w_lp'(width_p - 1);

`ifdef FIFO_SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd3,
    PARITY = 3'd4
  } state_t;

  logic parity_r;

  function automatic logic parity_f(input logic [width_p-1:0] word);
    parity_f = ^word;
  endfunction
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3
  } state_t;
`endif

  state_t              state_r;
  logic [cnt_w_lp-1:0] cnt_r;
  logic [idx_w_lp-1:0] idx_r;
  logic [width_p-1:0]  shift_r;
  logic                tx_r;
  logic                busy_r;

  logic                bit_done_s;
  logic                yumi_s;
  logic [width_p-1:0]  shift_nxt_s;

  // Handshake and bit-boundary decode; yumi is suppressed while reset is asserted.
  always_comb begin
    bit_done_s  = (cnt_r == cnt_last_lp);
    shift_nxt_s = shift_r >> 1;
    yumi_s      = valid_i && !reset_i &&
                  ((state_r == IDLE) || ((state_r == STOP) && bit_done_s));
  end

  assign yumi_o = yumi_s;
  assign tx_o   = tx_r;
  assign busy_o = busy_r;

  // Frame FSM; the shift register is deliberately left out of the reset branch.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      idx_r   <= '0;
      tx_r    <= 1'b1;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= '0;
          idx_r <= '0;
          if (yumi_s) begin
            shift_r <= data_i;
`ifdef FIFO_SERIAL_TX_PARITY_EN
            parity_r <= parity_f(data_i);
`endif
            state_r <= START;
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        START: begin
          if (bit_done_s) begin
            cnt_r   <= '0;
            idx_r   <= '0;
            state_r <= DATA;
            tx_r    <= shift_r[0];
          end else begin
            cnt_r <= cnt_r + cnt_w_lp'(1);
          end
        end
        DATA: begin
          if (bit_done_s) begin
            cnt_r <= '0;
            if (idx_r == idx_last_lp) begin
`ifdef FIFO_SERIAL_TX_PARITY_EN
              state_r <= PARITY;
              tx_r    <= parity_r;
`else
              state_r <= STOP;
              tx_r    <= 1'b1;
`endif
            end else begin
              idx_r   <= idx_r + idx_w_lp'(1);
              shift_r <= shift_nxt_s;
              tx_r    <= shift_nxt_s[0];
            end
          end else begin
            cnt_r <= cnt_r + cnt_w_lp'(1);
          end
        end
`ifdef FIFO_SERIAL_TX_PARITY_EN
        PARITY: begin
          if (bit_done_s) begin
            cnt_r   <= '0;
            state_r <= STOP;
            tx_r    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + cnt_w_lp'(1);
          end
        end
`endif
        STOP: begin
          if (bit_done_s) begin
            cnt_r <= '0;
            idx_r <= '0;
            // A waiting word starts its frame with no idle gap.
            if (yumi_s) begin
              shift_r <= data_i;
`ifdef FIFO_SERIAL_TX_PARITY_EN
              parity_r <= parity_f(data_i);
`endif
              state_r <= START;
              tx_r    <= 1'b0;
              busy_r  <= 1'b1;
            end else begin
              state_r <= IDLE;
              tx_r    <= 1'b1;
              busy_r  <= 1'b0;
            end
          end else begin
            cnt_r <= cnt_r + cnt_w_lp'(1);
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          idx_r   <= '0;
          tx_r    <= 1'b1;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
